// File: rtl/dff_pair_pkg.sv
// Shared constants and the per-bit logic function for the dff_pair_unit register pair.
package dff_pair_pkg;

  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_NAND = 3;

  // Any code outside the legal set falls back to AND.
  function automatic logic apply_op(input int op, input logic a, input logic b);
    logic r;
    r = a & b;
    case (op)
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dff_reg.sv
// Generic WIDTH-bit register with synchronous active-low reset to a replicated constant
// and a load enable (tie en high for a plain D flip-flop).
module dff_reg #(
  parameter int   WIDTH = 1,
  parameter logic RST_Q = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: reset is tested inside the clocked block only, so it is synchronous and wins
  // over en; state is always assigned with <= so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= {WIDTH{RST_Q}};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_pair_unit.sv
// Two independent registered channels: q follows data, c follows OP(a,b) bitwise.
// Optional feature: define DFF_HOLD_EN to add an en port that holds both registers when low.
module dff_pair_unit
  import dff_pair_pkg::*;
#(
  parameter int   WIDTH = 1,
  parameter int   OP    = 0,
  parameter logic RST_Q = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DFF_HOLD_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c
);

  if (OP < OP_AND || OP > OP_NAND) begin : g_bad_op
    $error("dff_pair_unit: OP=%0d is not one of AND/OR/XOR/NAND (0..3)", OP);
  end

  logic             load_en;
  logic [WIDTH-1:0] c_next;

`ifdef DFF_HOLD_EN
  assign load_en = en;
`else
  assign load_en = 1'b1;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_op
    assign c_next[i] = apply_op(OP, a[i], b[i]);
  end

  dff_reg #(.WIDTH(WIDTH), .RST_Q(RST_Q)) u_data_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .d     (data),
    .q     (q)
  );

  dff_reg #(.WIDTH(WIDTH), .RST_Q(RST_Q)) u_logic_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .d     (c_next),
    .q     (c)
  );

endmodule

// File: tb/tb_dff_pair_unit.sv
// Self-checking bench: four 8-bit instances (OP=0..3) driven in parallel, compared against
// an edge-level reference model built directly from the register-pair behaviour.
module tb_dff_pair_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en_i;
  logic [W-1:0] data;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q_o [4];
  logic [W-1:0] c_o [4];

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q;
  logic [W-1:0] exp_c [4];
  bit           model_valid = 1'b0;

  always #10 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    dff_pair_unit #(.WIDTH(W), .OP(gi), .RST_Q(1'b0)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef DFF_HOLD_EN
      .en    (en_i),
`endif
      .data  (data),
      .q     (q_o[gi]),
      .a     (a),
      .b     (b),
      .c     (c_o[gi])
    );
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      0:       return x & y;
      1:       return x | y;
      2:       return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_q_op%0d", tag, i), q_o[i], exp_q);
      check($sformatf("%s_c_op%0d", tag, i), c_o[i], exp_c[i]);
    end
  endtask

  // Drive inputs on the falling edge, advance the model on the rising edge, then check mid-high.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [W-1:0] d, input logic [W-1:0] x, input logic [W-1:0] y);
    logic load;
    @(negedge clk);
    rst_n = r; en_i = e; data = d; a = x; b = y;
    @(posedge clk);
`ifdef DFF_HOLD_EN
    load = e;
`else
    load = 1'b1;
`endif
    if (!r) begin
      exp_q = '0;
      for (int i = 0; i < 4; i++) exp_c[i] = '0;
      model_valid = 1'b1;
    end else if (load) begin
      exp_q = d;
      for (int i = 0; i < 4; i++) exp_c[i] = ref_op(i, x, y);
    end
    #5;
    if (model_valid) check_all(tag);
  endtask

  logic       seq_d  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0] seq_ab [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};

  initial begin
    rst_n = 1'b0; en_i = 1'b1; data = '0; a = '0; b = '0;

    // Reset for two edges with all inputs high, then release.
    step("rst1", 1'b0, 1'b1, '1, '1, '1);
    step("rst2", 1'b0, 1'b1, '1, '1, '1);
    step("release", 1'b1, 1'b1, '1, '1, '1);

    // Truth-table walk across all four ops.
    for (int i = 0; i < 6; i++)
      step("seq", 1'b1, 1'b1, {W{seq_d[i]}}, {W{seq_ab[i][1]}}, {W{seq_ab[i][0]}});

    // Same walk with a one-edge reset in the middle.
    for (int i = 0; i < 6; i++)
      step("seq_rst", (i != 3), 1'b1, {W{seq_d[i]}}, {W{seq_ab[i][1]}}, {W{seq_ab[i][0]}});

    // Inputs toggling between edges must not reach the outputs.
    step("pre_toggle", 1'b1, 1'b1, 8'h5A, 8'hF0, 8'h0F);
    for (int k = 0; k < 4; k++) begin
      #2;
      data = ~data; a = ~a; b = b ^ 8'h33;
      #1;
      check("toggle_q", q_o[0], exp_q);
      check("toggle_c", c_o[2], exp_c[2]);
    end
    step("post_toggle", 1'b1, 1'b1, 8'hC3, 8'hAA, 8'h55);

`ifdef DFF_HOLD_EN
    step("hold_load", 1'b1, 1'b1, 8'hA5, 8'h0F, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      step("hold", 1'b1, 1'b0, 8'h3C, 8'hFF, 8'h00);
      check("hold_a5", q_o[0], 8'hA5);
    end
    step("hold_rst", 1'b0, 1'b0, 8'h3C, 8'hFF, 8'hFF);
    check("hold_rst_zero", q_o[0], 8'h00);
`endif

    // Randomised traffic with occasional resets (and enable drops when present).
    for (int n = 0; n < 300; n++)
      step("rand", ($urandom_range(15) != 0), ($urandom_range(3) != 0),
           W'($urandom), W'($urandom), W'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
